// File: rtl/quantum_scheduler_pkg.sv
// Shared types for the preemption timer: scheduler states, interrupt cause codes, default widths.
// Pure declarations; no logic, no latency, no flow control.
package quantum_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam logic CAUSE_QNT = 1'b0;
    localparam logic CAUSE_EXT = 1'b1;

    localparam int DEF_QNT_W       = 16;
    localparam int DEF_QNT_DEFAULT = 32;
    localparam int DEF_ADDR_W      = 10;

endpackage

// File: rtl/quantum_scheduler_counter.sv
// Retired-instruction counter with clear/increment, zero-quantum disable and a combinational expiry flag.
// Count updates on the edge after clr/inc; expire is same-cycle with the expiring inc; no backpressure.
module qnt_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] quantum_i,
    output logic [W-1:0] count_o,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;
    logic [W:0]   next_w;

    // Extra bit keeps the >= test honest when the count sits at all-ones.
    assign next_w   = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign expire_o = inc_i && (quantum_i != '0) && (next_w >= {1'b0, quantum_i});
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (expire_o) begin
            count_d = quantum_i;
        end else if (inc_i) begin
            count_d = next_w[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemption timer/interrupt sequencer; intSig rises 1 cycle after the expiring tick, held until intAck.
// External interrupts are enabled with `define QUANTUM_EXT_INT_EN; no backpressure beyond the intAck handshake.
module quantum_scheduler
    import quantum_pkg::*;
#(
    parameter int QNT_W       = DEF_QNT_W,
    parameter int QNT_DEFAULT = DEF_QNT_DEFAULT,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INT_ADDR    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              halt,
    input  logic              stopQnt,
    input  logic              rstQnt,
    input  logic              qntWe,
    input  logic [QNT_W-1:0]  qntData,
    input  logic              intAck,
    input  logic              extReq,
    output logic              intSig,
    output logic              intCause,
    output logic [ADDR_W-1:0] intAddr,
    output logic [QNT_W-1:0]  qntCount,
    output logic              running
);

    state_e           state_q, state_d;
    logic [QNT_W-1:0] quantum_q, quantum_d;
    logic             cnt_clr, cnt_inc, cnt_expire;
    logic             ext_take;

`ifdef QUANTUM_EXT_INT_EN
    logic   ext_pend_q, ext_pend_d;
    logic   cause_q, cause_d;
    state_e ret_q, ret_d;

    assign ext_take = ext_pend_q && (state_q != PEND);
    assign intCause = cause_q;
`else
    logic unused_ext;

    assign unused_ext = extReq;
    assign ext_take   = 1'b0;
    assign intCause   = CAUSE_QNT;
`endif

    // stopQnt outranks rstQnt and expiry; a pending external request outranks all three.
    assign cnt_inc = (state_q == RUN) && tick && !halt && !stopQnt && !rstQnt && !ext_take;

    qnt_counter #(.W(QNT_W)) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .quantum_i (quantum_q),
        .count_o   (qntCount),
        .expire_o  (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        quantum_d = qntWe ? qntData : quantum_q;
        cnt_clr   = 1'b0;
`ifdef QUANTUM_EXT_INT_EN
        cause_d    = cause_q;
        ret_d      = ret_q;
        ext_pend_d = extReq || (ext_pend_q && !ext_take);
        if (ext_take) begin
            state_d = PEND;
            cause_d = CAUSE_EXT;
            ret_d   = state_q;
        end else
`endif
        case (state_q)
            STOP: begin
                if (rstQnt && !stopQnt) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (stopQnt) begin
                    state_d = STOP;
                end else if (rstQnt) begin
                    cnt_clr = 1'b1;
                end else if (cnt_expire) begin
                    state_d = PEND;
`ifdef QUANTUM_EXT_INT_EN
                    cause_d = CAUSE_QNT;
`endif
                end
            end
            PEND: begin
                if (intAck) begin
`ifdef QUANTUM_EXT_INT_EN
                    if (cause_q == CAUSE_EXT) begin
                        state_d = ret_q;
                    end else begin
                        state_d = STOP;
                        cnt_clr = 1'b1;
                    end
`else
                    state_d = STOP;
                    cnt_clr = 1'b1;
`endif
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STOP;
            quantum_q <= QNT_W'(QNT_DEFAULT);
`ifdef QUANTUM_EXT_INT_EN
            cause_q    <= CAUSE_QNT;
            ret_q      <= STOP;
            ext_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            quantum_q <= quantum_d;
`ifdef QUANTUM_EXT_INT_EN
            cause_q    <= cause_d;
            ret_q      <= ret_d;
            ext_pend_q <= ext_pend_d;
`endif
        end
    end

    assign intSig  = (state_q == PEND);
    assign running = (state_q == RUN);
    assign intAddr = ADDR_W'(INT_ADDR);

endmodule
